// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / MDU hazard detection and pipeline stall/flush control.
// Optional feature: define PIPE_HAZARD_CTRL_PERF_EN to build the stallCycles counter.
module pipe_hazard_ctrl #(
    parameter int MDU_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_useRs,
    input  logic        ID_useRt,
    input  logic        ID_MDUStart,
    input  logic        ID_MDUUse,
    input  logic        ID_branchTaken,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_writeReg,
    output logic        PC_stall,
    output logic        IF_ID_stall,
    output logic        IF_ID_flush,
    output logic        ID_EX_clearCtrl,
    output logic        MDU_issue,
    output logic        MDU_busy,
    output logic        MDU_done,
    output logic [31:0] stallCycles
);
    typedef enum logic {S_IDLE, S_BUSY} mdu_state_t;

    localparam logic [5:0] LP_CYC = 6'(MDU_CYCLES);

    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_nxt;
    logic        r_done;
    mdu_state_t  w_state;
    logic        w_loadUse;
    logic        w_mduHaz;
    logic        w_stall;
    logic        w_issue;

    // The counter value is the MDU state: zero means idle.
    assign w_state = (r_cnt != 6'd0) ? S_BUSY : S_IDLE;

    // Hazard detection; everything is gated off while reset is held.
    always_comb begin
        w_loadUse = EX_MemRead && (EX_writeReg != 5'd0) &&
                    ((ID_useRs && (ID_rs == EX_writeReg)) ||
                     (ID_useRt && (ID_rt == EX_writeReg)));
        w_mduHaz  = (w_state == S_BUSY) && (ID_MDUStart || ID_MDUUse);
        w_stall   = !rst && (w_loadUse || w_mduHaz);
        w_issue   = !rst && ID_MDUStart && !w_stall;
    end

    // MDU next-state: load on issue from idle, count down while busy.
    // A start seen while busy is stalled by mduHaz, so no reload happens.
    always_comb begin
        w_cnt_nxt = r_cnt;
        case (w_state)
            S_IDLE:  if (w_issue) w_cnt_nxt = LP_CYC;
            S_BUSY:  w_cnt_nxt = r_cnt - 6'd1;
            default: w_cnt_nxt = 6'd0;
        endcase
    end

    // MDU state register and registered completion pulse on the 1->0 step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 6'd0;
            r_done <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_done <= (r_cnt == 6'd1);
        end
    end

    assign PC_stall        = w_stall;
    assign IF_ID_stall     = w_stall;
    assign ID_EX_clearCtrl = w_stall;
    // A stalled branch is not flushed; it is re-evaluated next cycle.
    assign IF_ID_flush     = !rst && ID_branchTaken && !w_stall;
    assign MDU_issue       = w_issue;
    assign MDU_busy        = !rst && (w_state == S_BUSY);
    assign MDU_done        = r_done;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] r_stallCycles;

    // Count every edge on which the PC is held; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_stallCycles <= 32'h0;
        else if (w_stall) r_stallCycles <= r_stallCycles + 32'h1;
    end

    assign stallCycles = r_stallCycles;
`else
    assign stallCycles = 32'h0;
`endif

endmodule
